// File: rtl/debug_dump_sequencer.sv
// Streams a MIPS state snapshot (PC, cycle count, register file, data memory) over UART TX, LSB byte first.
// Optional feature macro: DUMP_CHECKSUM_EN appends one XOR checksum byte after the last memory byte.
module debug_dump_sequencer #(
  parameter int BITS_SIZE     = 32,
  parameter int SIZE_TRAMA    = 8,
  parameter int NUM_REGS      = 32,
  parameter int NUM_MEM_WORDS = 16,
  parameter int REG_ADDR_W    = $clog2(NUM_REGS)
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic                  i_start,
  input  logic [BITS_SIZE-1:0]  i_mips_pc,
  input  logic [BITS_SIZE-1:0]  i_clk_wiz_count,
  input  logic [BITS_SIZE-1:0]  i_data_reg_file,
  input  logic [BITS_SIZE-1:0]  i_data_mem,
  input  logic                  i_tx_done,
  output logic                  o_tx_start,
  output logic [SIZE_TRAMA-1:0] o_tx_data,
  output logic [REG_ADDR_W-1:0] o_select_register_dir,
  output logic [BITS_SIZE-1:0]  o_select_mem_dir,
  output logic                  o_busy,
  output logic                  o_done,
  output logic [2:0]            o_dbg_state
);

  localparam int BYTES  = BITS_SIZE / SIZE_TRAMA;
  localparam int BYTE_W = (BYTES > 1) ? $clog2(BYTES) : 1;
  localparam logic [REG_ADDR_W-1:0] REG_LAST = REG_ADDR_W'(NUM_REGS - 1);
  localparam logic [BITS_SIZE-1:0]  MEM_LAST = BITS_SIZE'(NUM_MEM_WORDS - 1);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    LOAD    = 3'd1,
    CAPTURE = 3'd2,
    SEND    = 3'd3,
    WAIT    = 3'd4,
    FINISH  = 3'd5
  } state_t;

  typedef enum logic [2:0] {
    PH_PC    = 3'd0,
    PH_COUNT = 3'd1,
    PH_REG   = 3'd2,
    PH_MEM   = 3'd3,
    PH_CSUM  = 3'd4
  } phase_t;

  state_t                state, state_next;
  phase_t                phase;
  logic [BYTE_W-1:0]     byte_idx;
  logic [BITS_SIZE-1:0]  word;
  logic [BITS_SIZE-1:0]  pc_snap;
  logic [BITS_SIZE-1:0]  cnt_snap;
  logic [REG_ADDR_W-1:0] sel_reg;
  logic [BITS_SIZE-1:0]  sel_mem;
  logic                  last_byte;
  logic                  more_words;

`ifdef DUMP_CHECKSUM_EN
  logic [SIZE_TRAMA-1:0] csum;
  assign last_byte  = (phase == PH_CSUM) || (byte_idx == BYTE_W'(BYTES - 1));
  assign more_words = (phase != PH_CSUM);
`else
  assign last_byte  = (byte_idx == BYTE_W'(BYTES - 1));
  assign more_words = !((phase == PH_MEM) && (sel_mem == MEM_LAST));
`endif

  // Handshake: o_tx_start pulses one cycle in SEND with o_tx_data valid; o_tx_data stays put
  // until i_tx_done, which is honoured only while in WAIT.
  assign o_tx_start            = (state == SEND);
  assign o_done                = (state == FINISH);
  assign o_busy                = (state != IDLE);
  assign o_tx_data             = word[SIZE_TRAMA*byte_idx +: SIZE_TRAMA];
  assign o_select_register_dir = sel_reg;
  assign o_select_mem_dir      = sel_mem;
  assign o_dbg_state           = state;

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) state <= IDLE;
    else          state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (i_start) state_next = LOAD;
      LOAD:    state_next = CAPTURE;
      CAPTURE: state_next = SEND;
      SEND:    state_next = WAIT;
      WAIT: begin
        if (i_tx_done) begin
          if (!last_byte)     state_next = SEND;
          else if (more_words) state_next = LOAD;
          else                state_next = FINISH;
        end
      end
      FINISH:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      phase    <= PH_PC;
      byte_idx <= '0;
      word     <= '0;
      pc_snap  <= '0;
      cnt_snap <= '0;
      sel_reg  <= '0;
      sel_mem  <= '0;
`ifdef DUMP_CHECKSUM_EN
      csum     <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          // PC and count are latched together so the pair is coherent for the whole dump.
          if (i_start) begin
            pc_snap  <= i_mips_pc;
            cnt_snap <= i_clk_wiz_count;
            phase    <= PH_PC;
`ifdef DUMP_CHECKSUM_EN
            csum     <= '0;
`endif
          end
        end
        CAPTURE: begin
          byte_idx <= '0;
          case (phase)
            PH_PC:    word <= pc_snap;
            PH_COUNT: word <= cnt_snap;
            PH_REG:   word <= i_data_reg_file;
            PH_MEM:   word <= i_data_mem;
`ifdef DUMP_CHECKSUM_EN
            PH_CSUM:  word <= BITS_SIZE'(csum);
`endif
            default:  word <= '0;
          endcase
        end
        SEND: begin
`ifdef DUMP_CHECKSUM_EN
          if (phase != PH_CSUM) csum <= csum ^ o_tx_data;
`endif
        end
        WAIT: begin
          if (i_tx_done) begin
            if (!last_byte) begin
              byte_idx <= byte_idx + BYTE_W'(1);
            end else if (more_words) begin
              case (phase)
                PH_PC:    phase <= PH_COUNT;
                PH_COUNT: begin
                  phase   <= PH_REG;
                  sel_reg <= '0;
                end
                PH_REG: begin
                  if (sel_reg == REG_LAST) begin
                    phase   <= PH_MEM;
                    sel_mem <= '0;
                  end else begin
                    sel_reg <= sel_reg + REG_ADDR_W'(1);
                  end
                end
                PH_MEM: begin
`ifdef DUMP_CHECKSUM_EN
                  if (sel_mem == MEM_LAST) phase <= PH_CSUM;
                  else                     sel_mem <= sel_mem + BITS_SIZE'(1);
`else
                  sel_mem <= sel_mem + BITS_SIZE'(1);
`endif
                end
                default: phase <= PH_PC;
              endcase
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_debug_dump_sequencer.sv
// Directed bench for debug_dump_sequencer: a UART TX responder plus simple register/memory models,
// with each captured byte stream compared against a hand-built expected queue.
module tb_debug_dump_sequencer;

  localparam int BITS_SIZE     = 32;
  localparam int SIZE_TRAMA    = 8;
  localparam int NUM_REGS      = 32;
  localparam int NUM_MEM_WORDS = 16;
  localparam int REG_ADDR_W    = 5;
`ifdef DUMP_CHECKSUM_EN
  localparam int TOTAL = 201;
`else
  localparam int TOTAL = 200;
`endif

  logic                  clk;
  logic                  rst_n;
  logic                  start;
  logic [BITS_SIZE-1:0]  mips_pc;
  logic [BITS_SIZE-1:0]  clk_wiz_count;
  logic [BITS_SIZE-1:0]  data_reg_file;
  logic [BITS_SIZE-1:0]  data_mem;
  logic                  tx_done;
  logic                  tx_start;
  logic [SIZE_TRAMA-1:0] tx_data;
  logic [REG_ADDR_W-1:0] sel_reg;
  logic [BITS_SIZE-1:0]  sel_mem;
  logic                  busy;
  logic                  done;
  logic [2:0]            dbg_state;

  logic [7:0] exp_q[$];
  logic [7:0] got_q[$];
  int checks = 0;
  int errors = 0;
  int n_start;
  int n_done;
  bit timed_out;

  debug_dump_sequencer dut (
    .i_clk                 (clk),
    .i_reset               (rst_n),
    .i_start               (start),
    .i_mips_pc             (mips_pc),
    .i_clk_wiz_count       (clk_wiz_count),
    .i_data_reg_file       (data_reg_file),
    .i_data_mem            (data_mem),
    .i_tx_done             (tx_done),
    .o_tx_start            (tx_start),
    .o_tx_data             (tx_data),
    .o_select_register_dir (sel_reg),
    .o_select_mem_dir      (sel_mem),
    .o_busy                (busy),
    .o_done                (done),
    .o_dbg_state           (dbg_state)
  );

  // clock / reset / environment models
  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign data_reg_file = BITS_SIZE'(sel_reg);
  assign data_mem      = 32'h0000_00A0 + sel_mem;

  task automatic push_word(input logic [31:0] w);
    for (int b = 0; b < 4; b++) exp_q.push_back(w[8*b +: 8]);
  endtask

  task automatic build_expected(input logic [31:0] pc, input logic [31:0] cnt);
    logic [7:0] x;
    exp_q.delete();
    push_word(pc);
    push_word(cnt);
    for (int i = 0; i < NUM_REGS; i++) push_word(32'(i));
    for (int j = 0; j < NUM_MEM_WORDS; j++) push_word(32'hA0 + 32'(j));
    x = 8'h00;
    foreach (exp_q[i]) x = x ^ exp_q[i];
`ifdef DUMP_CHECKSUM_EN
    exp_q.push_back(x);
`endif
  endtask

  function automatic int first_diff();
    if (got_q.size() != exp_q.size()) return -2;
    foreach (exp_q[i]) if (got_q[i] !== exp_q[i]) return i;
    return -1;
  endfunction

  // driver: start pulse; optionally change PC/count right after acceptance
  task automatic kick(input bit change, input logic [31:0] pc2, input logic [31:0] cnt2);
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    if (change) begin
      mips_pc       = pc2;
      clk_wiz_count = cnt2;
    end
  endtask

  // UART responder: tx_done 3 cycles after each start; optional protocol disturbances
  task automatic collect(input int stop_after, input bit disturb);
    int pend;
    bit kicked;
    pend = -1;
    kicked = 1'b0;
    got_q.delete();
    n_start = 0;
    n_done = 0;
    timed_out = 1'b0;
    for (int cyc = 0; cyc < 5000; cyc++) begin
      @(negedge clk);
      start   = 1'b0;
      tx_done = 1'b0;
      if (done) begin
        n_done++;
        return;
      end
      if (pend == 0) begin
        tx_done = 1'b1;
        pend = -1;
      end else if (pend > 0) begin
        pend--;
      end
      if (tx_start) begin
        got_q.push_back(tx_data);
        n_start++;
        pend = 2;
        if (disturb && n_start == 20) tx_done = 1'b1;
        if (n_start == stop_after) return;
      end
      if (disturb && dbg_state == 3'd1) tx_done = 1'b1;
      if (disturb && !kicked && busy && n_start == 10) begin
        start  = 1'b1;
        kicked = 1'b1;
      end
    end
    timed_out = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #1;
    checks++;
    if ({tx_start, tx_data, busy, done} !== 11'd0) begin
      errors++;
      $display("FAIL reset_outputs: got start=%b data=%h busy=%b done=%b, expected all 0", tx_start, tx_data, busy, done);
    end
    checks++;
    if (sel_reg !== 5'd0 || sel_mem !== 32'd0) begin
      errors++;
      $display("FAIL reset_selects: got reg=%0d mem=%0d, expected 0 0", sel_reg, sel_mem);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset_mid_send();
    bit seen;
    seen = 1'b0;
    kick(1'b0, 32'd0, 32'd0);
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (tx_start) seen = 1'b1;
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL first_send: got no tx_start, expected one within 20 cycles");
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({tx_start, tx_data, busy, done} !== 11'd0) begin
      errors++;
      $display("FAIL reset_mid_send: got start=%b data=%h busy=%b done=%b, expected all 0", tx_start, tx_data, busy, done);
    end
    @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (tx_start || busy) seen = 1'b1;
    end
    checks++;
    if (seen) begin
      errors++;
      $display("FAIL post_reset_idle: got start/busy activity, expected none");
    end
  endtask

  task automatic test_full_dump();
    int d;
    build_expected(32'h0000_0040, 32'h0000_0123);
    kick(1'b0, 32'd0, 32'd0);
    collect(0, 1'b0);
    checks++;
    if (timed_out) begin
      errors++;
      $display("FAIL full_timeout: got %0d bytes, expected done", got_q.size());
    end
    d = first_diff();
    checks++;
    if (d != -1) begin
      errors++;
      $display("FAIL full_stream: got len %0d first diff %0d, expected len %0d identical", got_q.size(), d, exp_q.size());
    end
    checks++;
    if (n_start != TOTAL || n_done != 1) begin
      errors++;
      $display("FAIL full_counts: got starts=%0d done=%0d, expected %0d 1", n_start, n_done, TOTAL);
    end
    checks++;
    if (sel_reg !== 5'd31 || sel_mem !== 32'd15) begin
      errors++;
      $display("FAIL final_selects: got reg=%0d mem=%0d, expected 31 15", sel_reg, sel_mem);
    end
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL after_done: got busy=%b done=%b, expected 0 0", busy, done);
    end
  endtask

  task automatic test_snapshot();
    int d;
    build_expected(32'h0000_0040, 32'h0000_0123);
    kick(1'b1, 32'hDEAD_BEEF, 32'h0000_0055);
    collect(0, 1'b0);
    mips_pc       = 32'h0000_0040;
    clk_wiz_count = 32'h0000_0123;
    d = first_diff();
    checks++;
    if (timed_out || d != -1) begin
      errors++;
      $display("FAIL snapshot_stream: got len %0d first diff %0d, expected start-time PC/count", got_q.size(), d);
    end
  endtask

  task automatic test_protocol();
    int d;
    build_expected(32'h0000_0040, 32'h0000_0123);
    kick(1'b0, 32'd0, 32'd0);
    collect(0, 1'b1);
    d = first_diff();
    checks++;
    if (timed_out || d != -1) begin
      errors++;
      $display("FAIL protocol_stream: got len %0d first diff %0d, expected identical stream", got_q.size(), d);
    end
    checks++;
    if (n_start != TOTAL || n_done != 1) begin
      errors++;
      $display("FAIL protocol_counts: got starts=%0d done=%0d, expected %0d 1", n_start, n_done, TOTAL);
    end
    repeat (4) @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL no_queued_start: got busy=%b, expected 0", busy);
    end
  endtask

  task automatic test_abort();
    int d;
    build_expected(32'h0000_0040, 32'h0000_0123);
    kick(1'b0, 32'd0, 32'd0);
    collect(50, 1'b0);
    checks++;
    if (n_start != 50 || n_done != 0) begin
      errors++;
      $display("FAIL abort_partial: got starts=%0d done=%0d, expected 50 0", n_start, n_done);
    end
    // start asserted together with reset must lose
    start = 1'b1;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    start = 1'b0;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || tx_start !== 1'b0) begin
      errors++;
      $display("FAIL abort_reset: got busy=%b done=%b start=%b, expected 0 0 0", busy, done, tx_start);
    end
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL abort_idle: got busy=%b, expected 0", busy);
    end
    kick(1'b0, 32'd0, 32'd0);
    collect(0, 1'b0);
    d = first_diff();
    checks++;
    if (timed_out || d != -1 || n_done != 1) begin
      errors++;
      $display("FAIL abort_restart: got len %0d first diff %0d done=%0d, expected full stream from PC", got_q.size(), d, n_done);
    end
  endtask

  initial begin
    start         = 1'b0;
    tx_done       = 1'b0;
    mips_pc       = 32'h0000_0040;
    clk_wiz_count = 32'h0000_0123;
    rst_n         = 1'b1;
    test_reset();
    test_reset_mid_send();
    test_full_dump();
    test_snapshot();
    test_protocol();
    test_abort();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
